instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Sequential front end of the 8-bit core: owns the program counter, fetches 8-bit instruction words from instruction memory over a request/acknowledge handshake, and presents each word to the control unit with a valid/ready handshake. It consumes the control unit's PC decision (sequential, branch, jump, halt) at the moment an instruction is accepted, computes the next PC, and reports the link address for jump-and-link. It sits between instruction memory and the control unit.

## Interface
- PC_W, 8: program counter / instruction address width.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_W  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  8  fetched instruction word.
- instr  out  8  instruction presented to the control unit; op = instr[7:4], operand = instr[3:0].
- instr_pc  out  PC_W  address instr was fetched from.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  control unit accepts instr this cycle.
- pc_control  in  2  next-PC select, sampled only on accept: 00 sequential, 01 branch taken, 10 jump, 11 halt.
- jump_target  in  PC_W  absolute target for pc_control=10.
- link_en  in  1  on a jump accept, record a link address.
- link_pc  out  PC_W  return address (instr_pc+1) of the last linking jump.
- link_valid  out  1  one-cycle pulse when link_pc updates.
- halted  out  1  fetch stopped by halt.

## Operation
- States: IDLE, REQ, HOLD, HALT. Reset forces IDLE.
- IDLE: outputs quiet; unconditionally moves to REQ next cycle.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: capture imem_rdata into instr, pc into instr_pc; go to HOLD. Without ack: remain in REQ with address stable.
- HOLD: instr_valid=1; instr and instr_pc stable. Accept = instr_valid & instr_ready. On accept, pc updates and the FSM goes to REQ, or to HALT if pc_control=11. Without accept: remain in HOLD.
- Next pc on accept, all arithmetic modulo 2^PC_W (wraps, no error):
  - 00: instr_pc + 1.
  - 01: instr_pc + 1 + sign-extended instr[3:0] (range -8..+7).
  - 10: jump_target. If link_en=1, link_pc <= instr_pc + 1 and link_valid pulses for the next cycle.
  - 11: pc unchanged; enter HALT.
- pc_control, jump_target and link_en are ignored whenever accept=0.
- HALT: halted=1, imem_req=0, instr_valid=0. Exit only by reset.
- imem_ack outside REQ is ignored; no data is captured.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, link_pc=0, link_valid=0, halted=0, pc=RESET_PC.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- First imem_req is high 2 cycles after reset deasserts (IDLE, then REQ).
- Ack in cycle N: instr_valid=1 from N+1.
- Accept in cycle M: instr_valid=0 and imem_req=1 with the new address in M+1.
- Peak throughput is one instruction per 2 cycles, with ack on the first REQ cycle and ready held high.
- Reset mid-fetch or mid-hold clears state immediately; a late imem_ack after reset is dropped.
- link_valid is high for exactly one cycle per linking jump.

## Test plan
- Sequential fetch: RESET_PC=0, memory acks immediately, ready=1, pc_control=00 -> addresses 0,1,2,3 requested; instr_valid high every 2nd cycle; instr_pc matches each address.
- Backpressure and wait states: ack delayed 3 cycles and ready low for 4 cycles -> imem_addr stable during the wait; instr stable while held; exactly one accept per instruction.
- Branch: instr 0xCE at pc 0x10 with pc_control=01 -> next fetch at 0x0F (0x11 - 2). Instr 0xC7 at 0xFE -> next fetch at 0x06 (wrap).
- Jump with link: instr at 0x20, pc_control=10, jump_target=0x80, link_en=1 -> next fetch at 0x80; link_pc=0x21; link_valid high for 1 cycle.
- Halt: pc_control=11 on accept -> halted=1 from the next cycle; imem_req stays 0 for 20 cycles; ack pulses are ignored.
- Async reset while in HOLD, asserted mid-cycle -> outputs reach their reset values before the next edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Instruction-memory and control-unit handshake bundle for the
//               fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if #(
    parameter int PC_W = 8
) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [7:0]      imem_rdata;
    logic [7:0]      instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [1:0]      pc_control;
    logic [PC_W-1:0] jump_target;
    logic            link_en;
    logic [PC_W-1:0] link_pc;
    logic            link_valid;
    logic            halted;

    // Fetch-unit view
    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
               link_pc, link_valid, halted,
        input  imem_ack, imem_rdata, instr_ready, pc_control,
               jump_target, link_en
    );

    // Memory / control-unit view
    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
               link_pc, link_valid, halted,
        output imem_ack, imem_rdata, instr_ready, pc_control,
               jump_target, link_en
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC owner; fetches instruction words and hands them to the
//               control unit, applying its next-PC decision on accept.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic                clk,
    input  wire logic                reset,
    instruction_fetch_unit_if.master bus
);
    localparam logic [PC_W-1:0] c_one = PC_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [7:0]      r_instr;
    logic [PC_W-1:0] r_instr_pc;
    logic [PC_W-1:0] r_link_pc;
    logic            r_link_valid;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_branch_pc;
    logic            w_accept;
    logic            w_capture;
    logic            w_link;

    assign w_accept    = (r_state == HOLD) && bus.instr_ready;
    assign w_capture   = (r_state == REQ) && bus.imem_ack;
    assign w_seq_pc    = r_instr_pc + c_one;
    // Branch offset is the signed 4-bit operand field
    assign w_branch_pc = w_seq_pc + {{(PC_W-4){r_instr[3]}}, r_instr[3:0]};
    assign w_link      = w_accept && (bus.pc_control == 2'b10) && bus.link_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            IDLE: w_state_next = REQ;
            REQ: begin
                if (w_capture) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (w_accept) begin
                    w_state_next = REQ;
                    case (bus.pc_control)
                        2'b00:   w_pc_next = w_seq_pc;
                        2'b01:   w_pc_next = w_branch_pc;
                        2'b10:   w_pc_next = bus.jump_target;
                        default: w_state_next = HALT;
                    endcase
                end
            end
            HALT:    w_state_next = HALT;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_instr_pc   <= '0;
            r_link_pc    <= '0;
            r_link_valid <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_link_valid <= w_link;
            if (w_capture) begin
                r_instr    <= bus.imem_rdata;
                r_instr_pc <= r_pc;
            end
            if (w_link) begin
                r_link_pc <= w_seq_pc;
            end
        end
    end

    assign bus.imem_req    = (r_state == REQ);
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = (r_state == HOLD);
    assign bus.link_pc     = r_link_pc;
    assign bus.link_valid  = r_link_valid;
    assign bus.halted      = (r_state == HALT);
endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;
    localparam int PC_W = 8;

    logic clk;
    logic reset;
    logic r_auto_ack;
    logic r_man_ack;
    logic [7:0] mem [256];
    int errors;
    int checks;

    instruction_fetch_unit_if #(.PC_W(PC_W)) bus ();

    instruction_fetch_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory answers from its own table; ack is either automatic or manual
    assign bus.imem_rdata = mem[bus.imem_addr];
    assign bus.imem_ack   = r_auto_ack ? bus.imem_req : r_man_ack;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in REQ at exp_pc: fetch, check presented word, accept with ctrl
    task automatic fetch_accept(input logic [1:0] ctrl, input logic [7:0] tgt,
                                input logic lnk, input logic [7:0] exp_pc);
        check("req_addr", {24'd0, bus.imem_addr}, {24'd0, exp_pc});
        check("req_high", {31'd0, bus.imem_req}, 32'd1);
        bus.pc_control  = ctrl;
        bus.jump_target = tgt;
        bus.link_en     = lnk;
        bus.instr_ready = 1'b1;
        step();
        check("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("hold_instr", {24'd0, bus.instr}, {24'd0, mem[exp_pc]});
        check("hold_pc", {24'd0, bus.instr_pc}, {24'd0, exp_pc});
        step();
        bus.pc_control  = 2'b00;
        bus.jump_target = 8'h00;
        bus.link_en     = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hCE;
        mem[8'hFE] = 8'hC7;
        mem[8'h80] = 8'hF0;
        r_auto_ack = 1'b0;
        r_man_ack  = 1'b0;
        bus.instr_ready = 1'b0;
        bus.pc_control  = 2'b00;
        bus.jump_target = 8'h00;
        bus.link_en     = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("rst_instr", {24'd0, bus.instr}, 32'd0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_link_valid", {31'd0, bus.link_valid}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        step();
        step();
        reset = 1'b0;
        check("idle_req", {31'd0, bus.imem_req}, 32'd0);

        // Sequential fetch, immediate ack, ready high
        r_auto_ack = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check("seq_valid_low", {31'd0, bus.instr_valid}, 32'd0);
            fetch_accept(2'b00, 8'h00, 1'b0, 8'(i));
            check("seq_req_after", {31'd0, bus.imem_req}, 32'd0 + 1);
        end

        // Wait states then backpressure, at address 4
        r_auto_ack = 1'b0;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_addr", {24'd0, bus.imem_addr}, 32'h04);
            check("wait_valid", {31'd0, bus.instr_valid}, 32'd0);
        end
        r_man_ack = 1'b1;
        step();
        r_man_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
            check("bp_instr", {24'd0, bus.instr}, {24'd0, mem[4]});
            check("bp_pc", {24'd0, bus.instr_pc}, 32'h04);
            step();
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        check("bp_next_addr", {24'd0, bus.imem_addr}, 32'h05);
        check("bp_next_valid", {31'd0, bus.instr_valid}, 32'd0);
        step();
        check("bp_single_accept", {24'd0, bus.imem_addr}, 32'h05);

        // Branches, including wrap past 0xFF
        r_auto_ack = 1'b1;
        fetch_accept(2'b10, 8'h10, 1'b0, 8'h05);
        check("nolink_valid", {31'd0, bus.link_valid}, 32'd0);
        fetch_accept(2'b01, 8'h00, 1'b0, 8'h10);
        check("branch_back", {24'd0, bus.imem_addr}, 32'h0F);
        fetch_accept(2'b10, 8'hFE, 1'b0, 8'h0F);
        fetch_accept(2'b01, 8'h00, 1'b0, 8'hFE);
        check("branch_wrap", {24'd0, bus.imem_addr}, 32'h06);

        // Jump and link
        fetch_accept(2'b10, 8'h20, 1'b0, 8'h06);
        fetch_accept(2'b10, 8'h80, 1'b1, 8'h20);
        check("link_pc", {24'd0, bus.link_pc}, 32'h21);
        check("link_pulse", {31'd0, bus.link_valid}, 32'd1);
        step();
        check("link_pulse_end", {31'd0, bus.link_valid}, 32'd0);
        check("link_pc_hold", {24'd0, bus.link_pc}, 32'h21);

        // Halt, with stray acks
        bus.pc_control  = 2'b11;
        bus.instr_ready = 1'b1;
        step();
        bus.pc_control = 2'b00;
        r_auto_ack = 1'b0;
        check("halt_flag", {31'd0, bus.halted}, 32'd1);
        check("halt_addr", {24'd0, bus.imem_addr}, 32'h80);
        for (int i = 0; i < 20; i++) begin
            r_man_ack = 1'(i % 2);
            step();
            check("halt_req", {31'd0, bus.imem_req}, 32'd0);
            check("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
            check("halt_stay", {31'd0, bus.halted}, 32'd1);
        end
        r_man_ack = 1'b0;
        check("halt_instr_kept", {24'd0, bus.instr}, 32'hF0);

        // Restart, reach HOLD, then reset asynchronously mid-cycle
        reset = 1'b1;
        step();
        reset = 1'b0;
        r_auto_ack = 1'b1;
        bus.instr_ready = 1'b0;
        step();
        step();
        check("pre_rst_valid", {31'd0, bus.instr_valid}, 32'd1);
        #3 reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("arst_instr", {24'd0, bus.instr}, 32'd0);
        check("arst_link_pc", {24'd0, bus.link_pc}, 32'd0);
        check("arst_halted", {31'd0, bus.halted}, 32'd0);
        r_auto_ack = 1'b0;
        r_man_ack  = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("late_ack_dropped", {31'd0, bus.instr_valid}, 32'd0);
        check("restart_req", {31'd0, bus.imem_req}, 32'd1);
        check("restart_addr", {24'd0, bus.imem_addr}, 32'h00);
        step();
        r_man_ack = 1'b0;
        check("restart_fetch", {24'd0, bus.instr}, {24'd0, mem[0]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
